// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: ALU ops, RV32 opcodes,
// error codes, FSM states and the request decoder.
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [7:0] ERR_OK     = 8'h00;
  localparam logic [7:0] ERR_UNSUPM = 8'h02;
  localparam logic [7:0] ERR_BADOP  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    K_ALU,
    K_LUI,
    K_BR,
    K_MUL,
    K_BAD
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    alu_op_e    op;
    logic       use_imm;
    logic [7:0] err;
  } dec_t;

  function automatic alu_op_e f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e o;
    case (f3)
      3'b000:  o = ALU_ADD;
      3'b001:  o = ALU_SLL;
      3'b010:  o = ALU_SLT;
      3'b011:  o = ALU_SLTU;
      3'b100:  o = ALU_XOR;
      3'b101:  o = alt ? ALU_SRA : ALU_SRL;
      3'b110:  o = ALU_OR;
      default: o = ALU_AND;
    endcase
    return o;
  endfunction

  function automatic logic [31:0] mag(
    input logic [31:0] x
  );
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic dec_t decode(
    input logic [6:0] opc,
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic       mul_en
  );
    dec_t d;
    d.kind    = K_BAD;
    d.op      = ALU_ADD;
    d.use_imm = 1'b0;
    d.err     = ERR_BADOP;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          d.kind = K_ALU;
          d.op   = f3_op(f3, 1'b0);
          d.err  = ERR_OK;
        end else if (f7 == F7_ALT &&
                     (f3 == 3'b000 || f3 == 3'b101)) begin
          d.kind = K_ALU;
          d.op   = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
          d.err  = ERR_OK;
        end else if (f7 == F7_MD) begin
          if (mul_en && (f3 == 3'b000 || f3 == 3'b001 ||
                         f3 == 3'b011)) begin
            d.kind = K_MUL;
            d.err  = ERR_OK;
          end else begin
            d.err  = ERR_UNSUPM;
          end
        end
      end
      OPC_OP_IMM: begin
        d.kind    = K_ALU;
        d.op      = f3_op(f3, f7[5]);
        d.use_imm = 1'b1;
        d.err     = ERR_OK;
      end
      OPC_LUI: begin
        d.kind = K_LUI;
        d.err  = ERR_OK;
      end
      OPC_BRANCH: begin
        if (f3[2:1] != 2'b01) begin
          d.kind = K_BR;
          d.op   = !f3[2] ? ALU_SUB :
                   (f3[1] ? ALU_SLTU : ALU_SLT);
          d.err  = ERR_OK;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_alu.sv
// Combinational RV32 ALU (v1): op, a, b -> y, zero.
// Shifts use b[4:0]; SLT/SLTU return 0/1.
module alu_issue_ctrl_alu
  import alu_issue_ctrl_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      default:  y = '0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU/branch/multiply unit with valid/ready req and rsp.
// req_* in -> EXEC (1 cycle) or MUL (33 cycles) -> RESP held until rsp_ready.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_br_taken,
  output logic [31:0] rsp_br_target,
  output logic [7:0]  rsp_error
);

  state_e      state, state_n;
  dec_t        dec_in, dec_q;
  logic [2:0]  f3_q;
  logic [31:0] rs1_q, rs2_q, imm_q, pc_q;
  logic [31:0] alu_b, alu_y;
  logic        alu_zero;
  logic        req_fire, is_mulh;
  logic [63:0] prod, prod_fix;
  logic [31:0] mcand;
  logic [32:0] step_sum;
  logic [4:0]  cnt;
  logic        fin, neg_q, hi_q;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign req_fire  = req_valid && req_ready;
  assign dec_in    = decode(req_opcode, req_funct3,
                            req_funct7, MUL_EN);
  assign is_mulh   = (req_funct3 == 3'b001);

  assign alu_b = dec_q.use_imm ? imm_q : rs2_q;

  alu_issue_ctrl_alu u_alu (
    .op   (dec_q.op),
    .a    (rs1_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Right-shifting shift-add: multiplier sits in prod[31:0], the
  // partial sum accumulates into the top half.
  assign step_sum = {1'b0, prod[63:32]} +
                    {1'b0, prod[0] ? mcand : 32'd0};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (req_fire)
          state_n = (dec_in.kind == K_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_n = S_RESP;
      S_MUL:  if (fin) state_n = S_RESP;
      S_RESP: if (rsp_ready) state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q         <= '0;
      f3_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      prod          <= '0;
      mcand         <= '0;
      cnt           <= '0;
      fin           <= 1'b0;
      neg_q         <= 1'b0;
      hi_q          <= 1'b0;
      rsp_result    <= '0;
      rsp_br_taken  <= 1'b0;
      rsp_br_target <= '0;
      rsp_error     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_fire) begin
            dec_q <= dec_in;
            f3_q  <= req_funct3;
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            imm_q <= req_imm;
            pc_q  <= req_pc;
            mcand <= is_mulh ? mag(req_rs1) : req_rs1;
            prod  <= {32'd0,
                      is_mulh ? mag(req_rs2) : req_rs2};
            neg_q <= is_mulh & (req_rs1[31] ^ req_rs2[31]);
            hi_q  <= (req_funct3 != 3'b000);
            cnt   <= '0;
            fin   <= 1'b0;
          end
        end
        S_EXEC: begin
          rsp_br_target <= pc_q + imm_q;
          rsp_error     <= dec_q.err;
          rsp_br_taken  <= 1'b0;
          rsp_result    <= '0;
          case (dec_q.kind)
            K_ALU: rsp_result <= alu_y;
            K_LUI: rsp_result <= imm_q;
            // f3[0] inverts: bne/bge/bgeu
            K_BR:  rsp_br_taken <= f3_q[0] ^
                     (f3_q[2] ? alu_y[0] : alu_zero);
            default: ;
          endcase
        end
        S_MUL: begin
          if (!fin) begin
            prod <= {step_sum, prod[31:1]};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) fin <= 1'b1;
          end else begin
            rsp_result    <= hi_q ? prod_fix[63:32]
                                  : prod_fix[31:0];
            rsp_br_taken  <= 1'b0;
            rsp_br_target <= pc_q + imm_q;
            rsp_error     <= ERR_OK;
          end
        end
        S_RESP: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl.
// One task per scenario; expectations are hand-computed constants.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid, req_ready;
  logic [6:0]  req_opcode, req_funct7;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2, req_imm, req_pc;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result, rsp_br_target;
  logic        rsp_br_taken;
  logic [7:0]  rsp_error;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] res;
  } vec_t;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.MUL_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opcode    (req_opcode),
    .req_funct3    (req_funct3),
    .req_funct7    (req_funct7),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_imm       (req_imm),
    .req_pc        (req_pc),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_br_taken  (rsp_br_taken),
    .rsp_br_target (rsp_br_target),
    .rsp_error     (rsp_error)
  );

  // Issue one request and return at the negedge where rsp_valid is
  // first seen; lat = posedges from transfer until rsp can transfer.
  task automatic send(
    input  logic [6:0]  opc,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output int          lat
  );
    int n;
    @(negedge clk);
    req_opcode = opc;
    req_funct3 = f3;
    req_funct7 = f7;
    req_rs1    = a;
    req_rs2    = b;
    req_imm    = imm;
    req_pc     = pc;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_wait: got %b want 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout: got %b want 1", rsp_valid);
    end
  endtask

  task automatic pop();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready: got %b want 1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid: got %b want 0", rsp_valid);
    end
    checks++;
    if ({rsp_result, rsp_br_target, rsp_error, rsp_br_taken}
        !== 73'd0) begin
      failures++;
      $display("FAIL rst_outputs: got %h %h %h %b want 0",
               rsp_result, rsp_br_target, rsp_error, rsp_br_taken);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rel_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    send(7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 32'h40, 32'h1000, lat);
    checks++;
    if (rsp_result !== 32'd12) begin
      failures++;
      $display("FAIL add_res: got %h want 0000000c", rsp_result);
    end
    checks++;
    if (rsp_error !== 8'h00) begin
      failures++;
      $display("FAIL add_err: got %h want 00", rsp_error);
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL add_lat: got %0d want 2", lat);
    end
    checks++;
    if (rsp_br_target !== 32'h1040 || rsp_br_taken !== 1'b0) begin
      failures++;
      $display("FAIL add_br: got %h/%b want 00001040/0",
               rsp_br_target, rsp_br_taken);
    end
    pop();
  endtask

  task automatic test_alu_ops();
    vec_t v[14];
    logic [31:0] pc;
    int lat;
    pc = 32'hFFFF_FFF0;
    v[0]  = '{7'h33, 3'd0, 7'h20, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE};
    v[1]  = '{7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'd0,
              32'hF800_0000};
    v[2]  = '{7'h33, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 32'd0,
              32'h0800_0000};
    v[3]  = '{7'h33, 3'd1, 7'h00, 32'd3, 32'h24, 32'd0, 32'h30};
    v[4]  = '{7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1};
    v[5]  = '{7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    v[6]  = '{7'h33, 3'd4, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,
              32'h0FF0_0FF0};
    v[7]  = '{7'h33, 3'd6, 7'h00, 32'hF0F0_F0F0, 32'h0F00_0000, 32'd0,
              32'hFFF0_F0F0};
    v[8]  = '{7'h33, 3'd7, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,
              32'hF000_F000};
    v[9]  = '{7'h13, 3'd0, 7'h20, 32'd10, 32'h1F, 32'hFFFF_FFFF, 32'd9};
    v[10] = '{7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'h1F, 32'h404,
              32'hF800_0000};
    v[11] = '{7'h37, 3'd0, 7'h00, 32'hDEAD, 32'hBEEF, 32'h1234_5000,
              32'h1234_5000};
    v[12] = '{7'h33, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1};
    v[13] = '{7'h13, 3'd4, 7'h00, 32'h0000_00FF, 32'd0, 32'hFFFF_FFFF,
              32'hFFFF_FF00};
    for (int i = 0; i < 14; i++) begin
      send(v[i].opc, v[i].f3, v[i].f7, v[i].a, v[i].b,
           v[i].imm, pc, lat);
      checks++;
      if (rsp_result !== v[i].res) begin
        failures++;
        $display("FAIL alu_res[%0d]: got %h want %h",
                 i, rsp_result, v[i].res);
      end
      checks++;
      if (rsp_error !== 8'h00 || rsp_br_taken !== 1'b0) begin
        failures++;
        $display("FAIL alu_flags[%0d]: got %h/%b want 00/0",
                 i, rsp_error, rsp_br_taken);
      end
      checks++;
      if (rsp_br_target !== pc + v[i].imm) begin
        failures++;
        $display("FAIL alu_tgt[%0d]: got %h want %h",
                 i, rsp_br_target, pc + v[i].imm);
      end
      checks++;
      if (lat != 2) begin
        failures++;
        $display("FAIL alu_lat[%0d]: got %0d want 2", i, lat);
      end
      pop();
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3 [7];
    logic [31:0] a  [7];
    logic [31:0] b  [7];
    logic        tk [7];
    int lat;
    f3[0] = 3'd4; a[0] = 32'hFFFF_FFFE; b[0] = 32'd1; tk[0] = 1'b1;
    f3[1] = 3'd6; a[1] = 32'hFFFF_FFFE; b[1] = 32'd1; tk[1] = 1'b0;
    f3[2] = 3'd0; a[2] = 32'd7;         b[2] = 32'd7; tk[2] = 1'b1;
    f3[3] = 3'd1; a[3] = 32'd7;         b[3] = 32'd7; tk[3] = 1'b0;
    f3[4] = 3'd5; a[4] = 32'hFFFF_FFFE; b[4] = 32'd1; tk[4] = 1'b0;
    f3[5] = 3'd7; a[5] = 32'hFFFF_FFFE; b[5] = 32'd1; tk[5] = 1'b1;
    f3[6] = 3'd1; a[6] = 32'd7;         b[6] = 32'd8; tk[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(7'h63, f3[i], 7'h00, a[i], b[i], 32'h20, 32'h100, lat);
      checks++;
      if (rsp_br_taken !== tk[i]) begin
        failures++;
        $display("FAIL br_taken[%0d]: got %b want %b",
                 i, rsp_br_taken, tk[i]);
      end
      checks++;
      if (rsp_br_target !== 32'h120 || rsp_result !== 32'd0 ||
          rsp_error !== 8'h00) begin
        failures++;
        $display("FAIL br_out[%0d]: got %h/%h/%h want 120/0/00",
                 i, rsp_br_target, rsp_result, rsp_error);
      end
      pop();
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f3  [5];
    logic [31:0] a   [5];
    logic [31:0] b   [5];
    logic [31:0] res [5];
    int lat;
    f3[0] = 3'd1; a[0] = 32'hFFFF_FFFE; b[0] = 32'd3;
    res[0] = 32'hFFFF_FFFF;
    f3[1] = 3'd0; a[1] = 32'hFFFF_FFFE; b[1] = 32'd3;
    res[1] = 32'hFFFF_FFFA;
    f3[2] = 3'd3; a[2] = 32'hFFFF_FFFE; b[2] = 32'd3;
    res[2] = 32'd2;
    f3[3] = 3'd1; a[3] = 32'hFFFF_FFFE; b[3] = 32'hFFFF_FFFD;
    res[3] = 32'd0;
    f3[4] = 3'd1; a[4] = 32'h8000_0000; b[4] = 32'h8000_0000;
    res[4] = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      send(7'h33, f3[i], 7'h01, a[i], b[i], 32'h8, 32'h200, lat);
      checks++;
      if (rsp_result !== res[i]) begin
        failures++;
        $display("FAIL mul_res[%0d]: got %h want %h",
                 i, rsp_result, res[i]);
      end
      checks++;
      if (lat != 34) begin
        failures++;
        $display("FAIL mul_lat[%0d]: got %0d want 34", i, lat);
      end
      checks++;
      if (rsp_error !== 8'h00 || rsp_br_target !== 32'h208) begin
        failures++;
        $display("FAIL mul_out[%0d]: got %h/%h want 00/208",
                 i, rsp_error, rsp_br_target);
      end
      pop();
    end
  endtask

  task automatic test_errors();
    logic [6:0] opc [4];
    logic [2:0] f3  [4];
    logic [6:0] f7  [4];
    logic [7:0] err [4];
    int lat;
    opc[0] = 7'h7F; f3[0] = 3'd0; f7[0] = 7'h00; err[0] = 8'hFF;
    opc[1] = 7'h33; f3[1] = 3'd4; f7[1] = 7'h01; err[1] = 8'h02;
    opc[2] = 7'h63; f3[2] = 3'd2; f7[2] = 7'h00; err[2] = 8'hFF;
    opc[3] = 7'h33; f3[3] = 3'd2; f7[3] = 7'h01; err[3] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      send(opc[i], f3[i], f7[i], 32'd9, 32'd9, 32'h10, 32'h300, lat);
      checks++;
      if (rsp_error !== err[i]) begin
        failures++;
        $display("FAIL err_code[%0d]: got %h want %h",
                 i, rsp_error, err[i]);
      end
      checks++;
      if (rsp_result !== 32'd0 || rsp_br_taken !== 1'b0 ||
          rsp_br_target !== 32'h310) begin
        failures++;
        $display("FAIL err_out[%0d]: got %h/%b/%h want 0/0/310",
                 i, rsp_result, rsp_br_taken, rsp_br_target);
      end
      checks++;
      if (lat != 2) begin
        failures++;
        $display("FAIL err_lat[%0d]: got %0d want 2", i, lat);
      end
      pop();
    end
  endtask

  task automatic test_hold();
    int lat;
    send(7'h33, 3'd0, 7'h00, 32'h11, 32'h22, 32'h4, 32'h500, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_result !== 32'h33 || rsp_br_target !== 32'h504 ||
          rsp_error !== 8'h00 || rsp_br_taken !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: got v%b r%b %h %h want 1 0 33 504",
                 i, rsp_valid, req_ready, rsp_result, rsp_br_target);
      end
    end
    pop();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: got r%b v%b want r1 v0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int nreq, nrsp, nboth;
    nreq = 0;
    nrsp = 0;
    nboth = 0;
    req_opcode = 7'h33;
    req_funct3 = 3'd0;
    req_funct7 = 7'h00;
    req_rs1    = 32'd100;
    req_rs2    = 32'd23;
    req_imm    = 32'd0;
    req_pc     = 32'd0;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (req_valid && req_ready) nreq++;
      if (rsp_valid && rsp_ready) begin
        nrsp++;
        checks++;
        if (rsp_result !== 32'd123) begin
          failures++;
          $display("FAIL b2b_res[%0d]: got %h want 0000007b",
                   i, rsp_result);
        end
      end
      if (req_ready && rsp_valid) nboth++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (nreq != 10 || nrsp != 10) begin
      failures++;
      $display("FAIL b2b_rate: got req%0d rsp%0d want 10 10",
               nreq, nrsp);
    end
    checks++;
    if (nboth != 0) begin
      failures++;
      $display("FAIL b2b_overlap: got %0d want 0", nboth);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, seen;
    @(negedge clk);
    req_opcode = 7'h33;
    req_funct3 = 3'd0;
    req_funct7 = 7'h01;
    req_rs1    = 32'd6;
    req_rs2    = 32'd7;
    req_imm    = 32'd0;
    req_pc     = 32'd0;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mul: got v%b r%b want v0 r1",
               rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_mul_ghost: got %0d want 0", seen);
    end
    send(7'h33, 3'd0, 7'h00, 32'd20, 32'd22, 32'd0, 32'd0, lat);
    checks++;
    if (rsp_result !== 32'd42 || lat != 2) begin
      failures++;
      $display("FAIL rst_mul_next: got %h lat%0d want 2a lat2",
               rsp_result, lat);
    end
    // Reset while parked in RESP.
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL rst_resp: got v%b %h want v0 0",
               rsp_valid, rsp_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_resp_ghost: got %0d want 0", seen);
    end
  endtask

  initial begin
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    req_opcode = '0;
    req_funct3 = '0;
    req_funct7 = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_imm    = '0;
    req_pc     = '0;
    test_reset();
    test_add();
    test_alu_ops();
    test_branch();
    test_mul();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter MUL_EN, default 1, meaning: 1 enables the iterative MUL/MULH/MULHU path, 0 flags all M-extension ops as unsupported.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid / req_ready  in / out  1 / 1  request handshake; transfer occurs when both are high at a clk edge.
REQ-005 req_opcode / req_funct3 / req_funct7  in  7 / 3 / 7  RV32 instruction fields.
REQ-006 req_rs1 / req_rs2 / req_imm / req_pc  in  32 each  operands, sign-extended immediate, instruction PC.
REQ-007 rsp_valid / rsp_ready  out / in  1 / 1  response handshake, same transfer rule.
REQ-008 rsp_result  out  32  ALU or multiplier result.
REQ-009 rsp_br_taken / rsp_br_target  out  1 / 32  branch decision; target = pc + imm.
REQ-010 rsp_error  out  8  0x00 ok, 0x02 unsupported M op, 0xFF undefined opcode.

Function
REQ-011 FSM states IDLE, EXEC, MUL, RESP; req_ready SHALL be high only in IDLE.
REQ-012 IDLE: on transfer, capture all req_* fields; go to MUL if the op is a supported multiply, else EXEC.
REQ-013 EXEC (one cycle): drive the ALU from captured fields, register result/flags/branch outputs, go to RESP.
REQ-014 Decode: OP (0110011) funct7=0000000 -> add/sll/slt/sltu/xor/srl/or/and by funct3; funct7=0100000 -> sub (f3=000), sra (f3=101).
REQ-015 OP-IMM (0010011) uses imm as b; srai when funct7[5]=1 and f3=101; funct7[5] is ignored for addi.
REQ-016 LUI (0110111): rsp_result = imm, no ALU dependence.
REQ-017 BRANCH (1100011): beq/bne use SUB zero flag; blt/bge use SLT bit 0; bltu/bgeu use SLTU bit 0; rsp_result = 0.
REQ-018 rsp_br_target SHALL be pc + imm modulo 2^32 for every request; rsp_br_taken = 0 for non-branch.
REQ-019 Any other opcode, or a branch f3 of 010/011: rsp_error = 0xFF, rsp_result = 0, taken = 0.
REQ-020 funct7=0000001: f3 000 MUL (low 32), 001 MULH (signed high), 011 MULHU (unsigned high); f3 010/1xx, or MUL_EN=0, -> rsp_error 0x02 through EXEC with result 0.
REQ-021 MUL: 32-cycle shift-add on operand magnitudes with a 5-bit counter; after count 31, apply two's-complement correction for MULH when signs differ, then go to RESP.
REQ-022 Latency: rsp_valid first high 2 cycles after the transfer edge for EXEC ops, 34 cycles after it for multiplies.
REQ-023 RESP: all rsp_* outputs SHALL hold stable while rsp_ready is low; on transfer go to IDLE.
REQ-024 A rsp_valid and rsp_ready both high in RESP SHALL NOT accept a new request in the same cycle (throughput 1 per 3 cycles minimum).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, with rsp_valid=0, rsp_result=0, rsp_br_taken=0, rsp_br_target=0, rsp_error=0, and mul counter=0.
REQ-026 Reset asserted mid-MUL or mid-RESP SHALL discard the operation; no response appears after release.
REQ-027 req_ready SHALL read 1 during reset and from the first edge after release.

Structure
REQ-028 Shared package SHALL hold the ALU op-code enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9), RV32 opcode constants, error codes and the FSM state enum.
REQ-029 The existing combinational ALU (ALU_v1) SHALL be the single instantiated sub-module; the multiplier is local logic.

Verification
REQ-030 ADD rs1=5, rs2=7 -> rsp_result=12, error=0x00, rsp_valid 2 cycles after transfer.
REQ-031 BLT rs1=0xFFFFFFFE, rs2=1, pc=0x100, imm=0x20 -> taken=1, target=0x120; BLTU with the same operands -> taken=0.
REQ-032 MULH rs1=0xFFFFFFFE, rs2=3 -> result 0xFFFFFFFF at transfer+34; MUL with the same operands -> 0xFFFFFFFA.
REQ-033 Opcode 0x7F -> error 0xFF, result 0; DIV (funct7=0000001, f3=100) -> error 0x02.
REQ-034 Hold rsp_ready low 5 cycles in RESP -> outputs stable and req_ready=0; release -> IDLE next cycle.
REQ-035 Assert rst_n low at cycle 10 of a MUL -> rsp_valid=0 immediately, no response after release, next ADD completes correctly.
